// File: rtl/irq_ctrl.sv
// Interrupt controller: edge-detects request lines into a pending set, alerts the
// fetch stage with the highest-priority enabled request, and tracks it through service.
module irq_ctrl #(
    parameter int          NUM_IRQ    = 4,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0010,
    localparam int         ID_W       = $clog2(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_req,
    input  logic [NUM_IRQ-1:0] irq_en,
    input  logic               stall,
    input  logic               interrupt_mask,
    input  logic               interrupt,
    input  logic               pci_take,
    output logic               alert,
    output logic [ID_W-1:0]    irq_id,
    output logic [31:0]        irq_vector,
    output logic               pending
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ALERT   = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] clr;
    logic               alert_d;
    logic [ID_W-1:0]    irq_id_d;
    logic [ID_W-1:0]    sel_id;
    logic               sel_valid;

    assign rise = irq_req & ~irq_q;

    // Set wins over clear so an edge arriving with the acknowledge is not lost.
    assign pend_d = (pend_q & ~clr) | rise;

    // Scan from the top so the lowest enabled index is the last one written.
    // NOTE: every output of a combinational block gets a default before any
    // branch; a path that leaves one unassigned infers a latch.
    always_comb begin
        sel_valid = 1'b0;
        sel_id    = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pend_q[i] && irq_en[i]) begin
                sel_valid = 1'b1;
                sel_id    = ID_W'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        alert_d  = alert;
        irq_id_d = irq_id;
        clr      = '0;
        case (state_q)
            IDLE: begin
                alert_d = 1'b0;
                if (sel_valid && !stall && !interrupt_mask) begin
                    irq_id_d = sel_id;
                    alert_d  = 1'b1;
                    state_d  = ALERT;
                end
            end
            ALERT: begin
                // Committed: enables, stall and newer requests cannot retarget it.
                alert_d = 1'b1;
                if (interrupt) begin
                    clr     = NUM_IRQ'(1) << irq_id;
                    alert_d = 1'b0;
                    state_d = SERVICE;
                end
            end
            SERVICE: begin
                alert_d = 1'b0;
                if (pci_take) begin
                    state_d = IDLE;
                end
            end
            default: begin
                alert_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= '0;
            irq_q   <= '0;
            alert   <= 1'b0;
            irq_id  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            irq_q   <= irq_req;
            alert   <= alert_d;
            irq_id  <= irq_id_d;
        end
    end

    assign irq_vector = VEC_BASE + VEC_STRIDE * 32'(irq_id);
    assign pending    = |(pend_q & irq_en);

endmodule
